// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/freeze sequencer for the 5-stage pipeline.
// Merges hazard, branch-taken and SRAM handshake into per-stage enables,
// owns the SRAM wait FSM with timeout, and keeps saturating event counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             sram_start,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_all,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic fa_raw, start_raw, terr_raw;
  logic fpc_raw, fif_raw, flush_raw, bub_raw;
  logic stall_ev, flush_ev;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // FSM state and wait-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic plus SRAM launch / global freeze decode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    fa_raw       = 1'b0;
    start_raw    = 1'b0;
    terr_raw     = 1'b0;
    case (state)
      RUN: begin
        wait_cnt_nxt = '0;
        if (mem_req) begin
          start_raw = 1'b1;
          fa_raw    = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // The pipe advances on the ready cycle itself.
        fa_raw = !sram_ready;
        if (sram_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt    = ERR;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERR: begin
        fa_raw   = 1'b1;
        terr_raw = 1'b1;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Stage-enable priority: freeze, then branch flush, then hazard stall.
  always_comb begin
    fpc_raw   = 1'b0;
    fif_raw   = 1'b0;
    flush_raw = 1'b0;
    bub_raw   = 1'b0;
    if (fa_raw) begin
      // Frozen registers keep hazard/branch; they are re-evaluated once unfrozen.
      fpc_raw = 1'b1;
      fif_raw = 1'b1;
    end else if (branch_taken) begin
      // The stalled instruction, if any, is squashed by the flush.
      flush_raw = 1'b1;
      bub_raw   = 1'b1;
    end else if (hazard_detected) begin
      fpc_raw = 1'b1;
      fif_raw = 1'b1;
      bub_raw = 1'b1;
    end
  end

  assign flush_ev = !fa_raw && branch_taken;
  assign stall_ev = !fa_raw && !branch_taken && hazard_detected;

  // Saturating performance counters, updated on the edge after the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall_ev) stall_cnt  <= sat_inc(stall_cnt);
      if (flush_ev) flush_cnt  <= sat_inc(flush_cnt);
      if (fa_raw)   freeze_cnt <= sat_inc(freeze_cnt);
    end
  end

  // Every control output is held low while reset is asserted.
  assign sram_start    = start_raw & ~rst;
  assign freeze_all    = fa_raw    & ~rst;
  assign timeout_err   = terr_raw  & ~rst;
  assign freeze_pc     = fpc_raw   & ~rst;
  assign freeze_if_id  = fif_raw   & ~rst;
  assign flush_if_id   = flush_raw & ~rst;
  assign bubble_id_exe = bub_raw   & ~rst;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_detected = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_req = 1'b0;
  logic sram_ready = 1'b0;

  logic        sram_start, freeze_pc, freeze_if_id, flush_if_id;
  logic        bubble_id_exe, freeze_all, timeout_err;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  logic        s_sram_start, s_freeze_pc, s_freeze_if_id, s_flush_if_id;
  logic        s_bubble_id_exe, s_freeze_all, s_timeout_err;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_freeze_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .sram_start(sram_start), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .bubble_id_exe(bubble_id_exe),
    .freeze_all(freeze_all), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .sram_start(s_sram_start), .freeze_pc(s_freeze_pc), .freeze_if_id(s_freeze_if_id),
    .flush_if_id(s_flush_if_id), .bubble_id_exe(s_bubble_id_exe),
    .freeze_all(s_freeze_all), .timeout_err(s_timeout_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .freeze_cnt(s_freeze_cnt)
  );

  // ---------------- behavioural model ----------------
  bit     m_busy = 0;   // an SRAM access is outstanding
  bit     m_err  = 0;   // timed out, sticky until reset
  int     m_waited = 0; // unready cycles spent waiting so far
  longint c_stall = 0, c_flush = 0, c_freeze = 0;

  function automatic bit m_fa();
    if (m_err) return 1'b1;
    if (m_busy) return !sram_ready;
    return mem_req;
  endfunction

  // {sram_start, freeze_all, freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, timeout_err}
  function automatic logic [6:0] m_ctrl();
    bit fa, st, fpc, fif, fl, bub;
    if (rst) return 7'd0;
    fa = m_fa();
    st = !m_err && !m_busy && mem_req;
    fpc = 0; fif = 0; fl = 0; bub = 0;
    if (fa) begin fpc = 1; fif = 1; end
    else if (branch_taken) begin fl = 1; bub = 1; end
    else if (hazard_detected) begin fpc = 1; fif = 1; bub = 1; end
    return {st, fa, fpc, fif, fl, bub, m_err};
  endfunction

  function automatic longint cap(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_err = 0; m_waited = 0;
      c_stall = 0; c_flush = 0; c_freeze = 0;
    end else begin
      bit fa;
      fa = m_fa();
      if (fa) c_freeze++;
      if (!fa && branch_taken) c_flush++;
      if (!fa && !branch_taken && hazard_detected) c_stall++;
      if (m_err) begin
        // stays in error
      end else if (!m_busy) begin
        if (mem_req) begin m_busy = 1; m_waited = 0; end
      end else if (sram_ready) begin
        m_busy = 0;
      end else begin
        m_waited++;
        if (m_waited == TO) begin m_busy = 0; m_err = 1; end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [6:0] e;
    e = m_ctrl();
    chk("ctrl", {sram_start, freeze_all, freeze_pc, freeze_if_id,
                 flush_if_id, bubble_id_exe, timeout_err}, e);
    chk("ctrl_s", {s_sram_start, s_freeze_all, s_freeze_pc, s_freeze_if_id,
                   s_flush_if_id, s_bubble_id_exe, s_timeout_err}, e);
    chk("stall_cnt",    stall_cnt,    rst ? 0 : cap(c_stall, 65535));
    chk("flush_cnt",    flush_cnt,    rst ? 0 : cap(c_flush, 65535));
    chk("freeze_cnt",   freeze_cnt,   rst ? 0 : cap(c_freeze, 65535));
    chk("stall_cnt_s",  s_stall_cnt,  rst ? 0 : cap(c_stall, 3));
    chk("flush_cnt_s",  s_flush_cnt,  rst ? 0 : cap(c_flush, 3));
    chk("freeze_cnt_s", s_freeze_cnt, rst ? 0 : cap(c_freeze, 3));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit h, input bit b, input bit m, input bit r, input bit rs);
    hazard_detected = h; branch_taken = b; mem_req = m; sram_ready = r; rst = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset forces controls low even with active inputs.
    tick();
    drive(1, 0, 1, 0, 1);
    #2;
    chk("lit_rst_start", sram_start, 0);
    chk("lit_rst_fpc", freeze_pc, 0);
    chk("lit_rst_stall", stall_cnt, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();

    // Two hazard cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      #2;
      chk("lit_haz_fpc", freeze_pc, 1);
      chk("lit_haz_bub", bubble_id_exe, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #2;
    chk("lit_haz_cnt", stall_cnt, 2);
    chk("lit_haz_release", freeze_pc, 0);
    tick();

    // Branch overrides hazard.
    drive(1, 1, 0, 0, 0);
    #2;
    chk("lit_br_flush", flush_if_id, 1);
    chk("lit_br_bub", bubble_id_exe, 1);
    chk("lit_br_fpc", freeze_pc, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("lit_br_fcnt", flush_cnt, 1);
    chk("lit_br_scnt", stall_cnt, 2);
    tick();

    // SRAM access ready after 3 wait cycles.
    drive(0, 0, 1, 0, 0);
    #2;
    chk("lit_mem_start", sram_start, 1);
    chk("lit_mem_fa0", freeze_all, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lit_mem_fa", freeze_all, 1);
      chk("lit_mem_nostart", sram_start, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    #2;
    chk("lit_mem_ready", freeze_all, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("lit_mem_fzcnt", freeze_cnt, 4);
    chk("lit_mem_run", freeze_all, 0);
    tick();

    // mem_req together with hazard: freeze wins, no stall counted.
    drive(1, 0, 1, 0, 0);
    #2;
    chk("lit_mh_fa", freeze_all, 1);
    chk("lit_mh_bub", bubble_id_exe, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("lit_mh_scnt", stall_cnt, 2);
    tick();

    // Timeout into ERR.
    drive(0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    #2;
    chk("lit_to_pre", timeout_err, 0);
    tick();
    drive(1, 1, 1, 1, 0);
    #2;
    chk("lit_to_err", timeout_err, 1);
    chk("lit_to_fa", freeze_all, 1);
    chk("lit_to_flush", flush_if_id, 0);
    chk("lit_to_start", sram_start, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    #2;
    chk("lit_to_rst_err", timeout_err, 0);
    chk("lit_to_rst_fa", freeze_all, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("lit_to_after", timeout_err, 0);
    tick();

    // Saturation on the narrow-counter instance.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    #2;
    chk("lit_sat_s", s_stall_cnt, 3);
    chk("lit_sat_w", stall_cnt, 5);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3,
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
            $urandom_range(0, 49) == 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
